fetch_controller: RTL
=====================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter PM_AW, default 5: program memory address width (32 words).
REQ-002 Parameter INSTR_W, default 16: instruction width, fields [15:11] opcode, [10:8] reg, [7:0] immediate.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  begin execution from address 0; honoured only in IDLE.
REQ-006 pm_addr  output  PM_AW  address to the combinational program memory; equals pc.
REQ-007 pm_data  input  INSTR_W  instruction word returned by program memory, same cycle.
REQ-008 instr  output  INSTR_W  registered instruction presented to the core.
REQ-009 instr_valid  output  1  instr holds a valid, unconsumed instruction.
REQ-010 instr_ready  input  1  core accepts instr this cycle.
REQ-011 branch_taken  input  1  redirect fetch; sampled only on an accept cycle.
REQ-012 branch_target  input  PM_AW  redirect address.
REQ-013 pc  output  PM_AW  current fetch address.
REQ-014 halted  output  1  HALT instruction has been accepted.
REQ-015 busy  output  1  high in FETCH or ISSUE.

Function
REQ-016 FSM states: IDLE, FETCH, ISSUE, HALTED.
REQ-017 IDLE: start=1 -> FETCH next cycle, pc=0; start=0 -> stay.
REQ-018 FETCH (one cycle): instr <= pm_data; pc <= pc+1 mod 2^PM_AW; -> ISSUE.
REQ-019 ISSUE: instr_valid=1; instr and pc stable while instr_ready=0.
REQ-020 Accept = ISSUE & instr_ready; exactly one accept per fetched word.
REQ-021 On accept with opcode == OPC_HALT: -> HALTED; pc unchanged; branch_taken ignored.
REQ-022 On accept, non-HALT, branch_taken=1: pc <= branch_target; -> FETCH.
REQ-023 On accept, non-HALT, branch_taken=0: -> FETCH; pc keeps incremented value.
REQ-024 Latency: start sampled in cycle N -> instr_valid=1 in cycle N+2 with instr = word at address 0.
REQ-025 Throughput: one instruction per 2 cycles with instr_ready held high.
REQ-026 Wrap: fetch at address 31 leaves pc=0; no flag, no stall.
REQ-027 HALTED: halted=1, instr_valid=0, busy=0; start ignored; exit only by reset.
REQ-028 branch_taken outside an accept cycle has no effect.
REQ-029 instr_valid combinational from state only, never from instr_ready.

Reset
REQ-030 reset=1 at a clock edge: state=IDLE, pc=0, instr=0, instr_valid=0, halted=0, busy=0, from any state including mid-ISSUE.
REQ-031 reset takes priority over start, instr_ready and branch_taken in the same cycle.

Structure
REQ-032 Shared package fetch_pkg holds the state enum, OPC_HALT = 5'b11111, and the opcode field bounds.
REQ-033 One sub-module program_counter (load, increment, wrap) is instantiated; the rest stays flat.
REQ-034 The bench instantiates the existing program_memory as the memory, with no glue logic.

Verification
REQ-035 Reset then start pulse, instr_ready=1 -> two cycles later instr_valid=1, instr=16'b00101_000_00010000, pc=1.
REQ-036 instr_ready held 0 for 3 cycles in ISSUE -> instr, pc=1 and instr_valid=1 unchanged; accept on 4th cycle -> next instr=16'b00111_001_00000000.
REQ-037 Accept with branch_taken=1, branch_target=20 -> next FETCH pm_addr=20; the same inputs with branch_taken=0 -> pm_addr=pc.
REQ-038 Force pc=31 via branch_target=31 -> word 31 (16'b0) issued, pc=0 afterwards.
REQ-039 Word with opcode 5'b11111 accepted -> halted=1, busy=0 next cycle; later start pulse -> no change.
REQ-040 reset asserted during ISSUE with instr_ready=0 -> next cycle state IDLE, instr_valid=0, pc=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller:
// FSM state encoding, HALT opcode and instruction field bounds.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_HALTED
  } fetch_state_e;

  localparam int unsigned OPC_HI = 15;
  localparam int unsigned OPC_LO = 11;

  localparam logic [OPC_HI-OPC_LO:0] OPC_HALT = 5'b11111;

endpackage

// File: rtl/fetch_controller_if.sv
// Program-memory and core-side handshake bundle of the fetch controller.
interface fetch_controller_if #(
  parameter int PM_AW   = 5,
  parameter int INSTR_W = 16
);

  logic [PM_AW-1:0]   pm_addr;
  logic [INSTR_W-1:0] pm_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_ready;
  logic               branch_taken;
  logic [PM_AW-1:0]   branch_target;

  modport master (
    output pm_addr,
    output instr,
    output instr_valid,
    input  pm_data,
    input  instr_ready,
    input  branch_taken,
    input  branch_target
  );

  modport slave (
    input  pm_addr,
    input  instr,
    input  instr_valid,
    output pm_data,
    output instr_ready,
    output branch_taken,
    output branch_target
  );

endinterface

// File: rtl/fetch_controller_program_counter.sv
// Fetch address register: synchronous clear, load (priority) or increment,
// wrapping modulo 2^AW.
module program_counter #(
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  output logic [AW-1:0] pc
);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_val;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/program_memory.sv
// Combinational program ROM: returns the word at addr in the same cycle.
module program_memory #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] data
);

  always_comb begin
    data = '0;
    case (int'(addr))
      0:       data = DW'(16'b00101_000_00010000);
      1:       data = DW'(16'b00111_001_00000000);
      2:       data = DW'(16'b00001_010_00000011);
      3:       data = DW'(16'b00010_011_00000100);
      20:      data = DW'(16'b01000_100_00010100);
      21:      data = DW'(16'b01001_101_00010101);
      25:      data = DW'(16'b11111_000_00000000);
      31:      data = '0;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction fetch FSM: fetches one word from a combinational program memory,
// holds it for the core until accepted, then follows branches or halts.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int PM_AW   = 5,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  fetch_controller_if.master fif,
  output logic [PM_AW-1:0]   pc,
  output logic               halted,
  output logic               busy
);

  fetch_state_e       state_q;
  fetch_state_e       state_d;
  logic [INSTR_W-1:0] instr_q;
  logic               accept;
  logic               is_halt;
  logic               pc_load;
  logic               pc_inc;
  logic [PM_AW-1:0]   pc_load_val;

  assign accept  = (state_q == ST_ISSUE) && fif.instr_ready;
  assign is_halt = (instr_q[OPC_HI:OPC_LO] == OPC_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_FETCH) begin
        instr_q <= fif.pm_data;
      end
    end
  end

  // The pc already points past the issued word, so a non-branching accept
  // only needs to return to FETCH.
  always_comb begin
    state_d     = state_q;
    pc_load     = 1'b0;
    pc_inc      = 1'b0;
    pc_load_val = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_load = 1'b1;
        end
      end
      ST_FETCH: begin
        pc_inc  = 1'b1;
        state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (accept) begin
          if (is_halt) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_FETCH;
            if (fif.branch_taken) begin
              pc_load     = 1'b1;
              pc_load_val = fif.branch_target;
            end
          end
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  program_counter #(
    .AW(PM_AW)
  ) u_program_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (pc_load),
    .load_val (pc_load_val),
    .inc      (pc_inc),
    .pc       (pc)
  );

  assign fif.pm_addr     = pc;
  assign fif.instr       = instr_q;
  assign fif.instr_valid = (state_q == ST_ISSUE);
  assign halted          = (state_q == ST_HALTED);
  assign busy            = (state_q == ST_FETCH) || (state_q == ST_ISSUE);

endmodule
